// File: rtl/hp_mul_seq.sv
// Sequential IEEE-754 binary16 multiplier: classify, 11-cycle shift-add multiply,
// normalize, round-to-nearest-even, with {invalid, overflow, underflow, inexact} flags.
module hp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p,
    output logic [3:0]  flags
);
    typedef enum logic [2:0] {IDLE, CLASS, MULT, NORM, ROUND, DONE} state_t;

    typedef struct packed {
        logic        snan;
        logic        qnan;
        logic        inf;
        logic        zero;
        logic [6:0]  e;
        logic [10:0] m;
    } opnd_t;

    state_t             state_q;
    logic [15:0]        a_q, b_q;
    logic [10:0]        ma_q, mb_q;
    logic signed [6:0]  exp_q;
    logic               sign_q, sticky_q;
    logic [21:0]        acc_q;
    logic [3:0]         cnt_q;

    function automatic logic [3:0] lead_shift(input logic [9:0] f);
        logic [3:0] sh;
        sh = 4'd10;
        for (int i = 0; i <= 9; i++) begin
            if (f[i]) sh = 4'(10 - i);
        end
        return sh;
    endfunction

    function automatic opnd_t unpack_op(input logic [15:0] x);
        opnd_t      o;
        logic [3:0] sh;
        o  = '0;
        sh = lead_shift(x[9:0]);
        if (x[14:10] == 5'h1F) begin
            if (x[9:0] != 10'd0) begin
                o.qnan = x[9];
                o.snan = ~x[9];
            end else begin
                o.inf = 1'b1;
            end
        end else if (x[14:10] == 5'd0) begin
            if (x[9:0] == 10'd0) begin
                o.zero = 1'b1;
            end else begin
                // Subnormal: pull the leading one up to bit 10 and charge the exponent
                o.m = {1'b0, x[9:0]} << sh;
                o.e = 7'(-7'sd14 - $signed({3'b000, sh}));
            end
        end else begin
            o.m = {1'b1, x[9:0]};
            o.e = 7'($signed({2'b00, x[14:10]}) - 7'sd15);
        end
        return o;
    endfunction

    opnd_t       opa, opb;
    logic        special_d, sgn_d;
    logic [15:0] sp_p_d;
    logic [3:0]  sp_f_d;

    always_comb begin
        opa       = unpack_op(a_q);
        opb       = unpack_op(b_q);
        sgn_d     = a_q[15] ^ b_q[15];
        special_d = 1'b1;
        sp_p_d    = 16'h0000;
        sp_f_d    = 4'b0000;
        if (opa.snan | opa.qnan | opb.snan | opb.qnan) begin
            sp_p_d = 16'h7E00;
            sp_f_d = {opa.snan | opb.snan, 3'b000};
        end else if ((opa.inf & opb.zero) | (opa.zero & opb.inf)) begin
            sp_p_d = 16'h7E00;
            sp_f_d = 4'b1000;
        end else if (opa.inf | opb.inf) begin
            sp_p_d = {sgn_d, 15'h7C00};
        end else if (opa.zero | opb.zero) begin
            sp_p_d = {sgn_d, 15'h0000};
        end else begin
            special_d = 1'b0;
        end
    end

    logic [21:0]       norm_acc_d;
    logic signed [6:0] norm_exp_d, norm_diff_d;
    logic [4:0]        norm_sh_d;
    logic              norm_st_d;

    always_comb begin
        norm_acc_d = acc_q;
        norm_exp_d = exp_q;
        norm_st_d  = 1'b0;
        norm_sh_d  = 5'd0;
        if (acc_q[21]) begin
            norm_st_d  = acc_q[0];
            norm_acc_d = acc_q >> 1;
            norm_exp_d = exp_q + 7'sd1;
        end
        norm_diff_d = -7'sd14 - norm_exp_d;
        // Below the normal range: denormalize to exponent -14, keeping lost bits as sticky
        if (norm_diff_d > 7'sd0) begin
            norm_sh_d  = (norm_diff_d > 7'sd24) ? 5'd24 : 5'(norm_diff_d);
            norm_st_d  = norm_st_d | (|(norm_acc_d & ~(22'h3FFFFF << norm_sh_d)));
            norm_acc_d = norm_acc_d >> norm_sh_d;
            norm_exp_d = -7'sd14;
        end
    end

    logic [10:0]       rnd_mant_d, rnd_mf_d;
    logic [11:0]       rnd_sum_d;
    logic              rnd_g_d, rnd_r_d, rnd_s_d, rnd_up_d, rnd_inx_d, rnd_tiny_d;
    logic signed [6:0] rnd_exp_d;
    logic [15:0]       rnd_p_d;
    logic [3:0]        rnd_f_d;

    always_comb begin
        rnd_mant_d = acc_q[20:10];
        rnd_g_d    = acc_q[9];
        rnd_r_d    = acc_q[8];
        rnd_s_d    = (|acc_q[7:0]) | sticky_q;
        rnd_up_d   = rnd_g_d & (rnd_r_d | rnd_s_d | rnd_mant_d[0]);
        rnd_inx_d  = rnd_g_d | rnd_r_d | rnd_s_d;
        rnd_tiny_d = ~acc_q[20];
        rnd_sum_d  = {1'b0, rnd_mant_d} + {11'd0, rnd_up_d};
        rnd_exp_d  = exp_q;
        rnd_mf_d   = rnd_sum_d[10:0];
        if (rnd_sum_d[11]) begin
            rnd_mf_d  = rnd_sum_d[11:1];
            rnd_exp_d = exp_q + 7'sd1;
        end
        if (rnd_exp_d > 7'sd15) begin
            rnd_p_d = {sign_q, 15'h7C00};
            rnd_f_d = 4'b0101;
        end else begin
            // A leading one at bit 10 means normal (this also covers subnormal promotion)
            rnd_p_d = rnd_mf_d[10] ? {sign_q, 5'(rnd_exp_d + 7'sd15), rnd_mf_d[9:0]}
                                   : {sign_q, 5'd0, rnd_mf_d[9:0]};
            rnd_f_d = {2'b00, rnd_tiny_d & rnd_inx_d, rnd_inx_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            p        <= 16'h0000;
            flags    <= 4'b0000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            ma_q     <= 11'd0;
            mb_q     <= 11'd0;
            exp_q    <= 7'sd0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            acc_q    <= 22'd0;
            cnt_q    <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        busy    <= 1'b1;
                        state_q <= CLASS;
                    end
                end
                CLASS: begin
                    cnt_q    <= 4'd0;
                    acc_q    <= 22'd0;
                    sticky_q <= 1'b0;
                    sign_q   <= sgn_d;
                    if (special_d) begin
                        p       <= sp_p_d;
                        flags   <= sp_f_d;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ma_q    <= opa.m;
                        mb_q    <= opb.m;
                        exp_q   <= $signed(opa.e) + $signed(opb.e);
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    if (mb_q[cnt_q]) acc_q <= acc_q + ({11'd0, ma_q} << cnt_q);
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd10) state_q <= NORM;
                end
                NORM: begin
                    acc_q    <= norm_acc_d;
                    exp_q    <= norm_exp_d;
                    sticky_q <= norm_st_d;
                    state_q  <= ROUND;
                end
                ROUND: begin
                    p       <= rnd_p_d;
                    flags   <= rnd_f_d;
                    done    <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hp_mul_seq.sv
// Directed bench for hp_mul_seq: vector table of hand-computed products plus
// reset-abort and back-to-back start sequences.
module tb_hp_mul_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] p;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    hp_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .p(p), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation; returns product, flags, done cycle and count of busy-low cycles.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb,
                         output logic [15:0] rp, output logic [3:0] rf,
                         output int lat, output int busy_gaps);
        int cyc;
        busy_gaps = 0;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (!busy) busy_gaps++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!busy) busy_gaps++;
        rp  = p;
        rf  = flags;
        lat = done ? cyc : -1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] rp;
        logic [3:0]  rf;
        int          lat, gaps, ndone;
        logic [15:0] bs [3];

        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 15};
        vecs[1]  = '{16'hC000, 16'h4200, 16'hC600, 4'b0000, 15};
        vecs[2]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 15};
        vecs[3]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 2};
        vecs[4]  = '{16'h7D00, 16'h3C00, 16'h7E00, 4'b1000, 2};
        vecs[5]  = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, 2};
        vecs[6]  = '{16'h0001, 16'h3800, 16'h0000, 4'b0011, 15};
        vecs[7]  = '{16'h0001, 16'h4000, 16'h0002, 4'b0000, 15};
        vecs[8]  = '{16'h0400, 16'h3800, 16'h0200, 4'b0000, 15};
        vecs[9]  = '{16'h8000, 16'h3C00, 16'h8000, 4'b0000, 2};
        vecs[10] = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000, 2};
        vecs[11] = '{16'h3E00, 16'h3E00, 16'h4080, 4'b0000, 15};
        vecs[12] = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 15};
        vecs[13] = '{16'h3E00, 16'h3C01, 16'h3E02, 4'b0001, 15};
        vecs[14] = '{16'h3E00, 16'h3C03, 16'h3E04, 4'b0001, 15};
        vecs[15] = '{16'hFBFF, 16'h7BFF, 16'hFC00, 4'b0101, 15};
        vecs[16] = '{16'h3C00, 16'h7D00, 16'h7E00, 4'b1000, 2};
        vecs[17] = '{16'h7C00, 16'hC000, 16'hFC00, 4'b0000, 2};

        rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p", 32'(p), 32'h0);
        chk("reset_flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].a, vecs[i].b, rp, rf, lat, gaps);
            chk($sformatf("v%0d_p", i), 32'(rp), 32'(vecs[i].p));
            chk($sformatf("v%0d_flags", i), 32'(rf), 32'(vecs[i].f));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy_gaps", i), 32'(gaps), 32'd0);
        end
        chk("p_held_after_done", 32'(p), 32'hFC00);

        // Reset in the middle of MULT: no done, outputs cleared, then a clean restart.
        @(negedge clk);
        a = 16'h3C00; b = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p", 32'(p), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        do_op(16'h3C00, 16'h4000, rp, rf, lat, gaps);
        chk("restart_p", 32'(rp), 32'h4000);
        chk("restart_flags", 32'(rf), 32'h0);
        chk("restart_latency", 32'(lat), 32'd15);

        // start held high; b changes every cycle, so only capture-edge values may appear.
        bs[0] = 16'h4000; bs[1] = 16'h4200; bs[2] = 16'h4400;
        ndone = 0;
        for (int k = 0; k < 49; k++) begin
            @(negedge clk);
            a = 16'h3C00; b = bs[k % 3]; start = 1'b1;
            @(posedge clk); #1;
            if (done) begin
                chk($sformatf("stream_cycle%0d", ndone), 32'(k + 1), 32'(15 + 16 * ndone));
                chk($sformatf("stream_p%0d", ndone), 32'(p), 32'(bs[ndone % 3]));
                ndone++;
            end
        end
        chk("stream_done_count", 32'(ndone), 32'd3);
        @(negedge clk);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hp_mul_seq.md
HP_MUL_SEQ -- requirements
Module: hp_mul_seq

Interface
REQ-001 The block SHALL have no parameters; the format is fixed IEEE-754 binary16, with 1 sign, 5 exponent (bias 15) and 10 fraction bits.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  16  multiplicand, binary16.
REQ-006 b  input  16  multiplier, binary16.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; p and flags valid in that cycle.
REQ-009 p  output  16  product, binary16, round-to-nearest-even.
REQ-010 flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-011 The states SHALL be IDLE, CLASS, MULT, NORM, ROUND and DONE; busy = (state != IDLE).
REQ-012 IDLE with start=1 SHALL capture a and b and go to CLASS; start SHALL be ignored in all other states.
REQ-013 CLASS (1 cycle) SHALL classify each operand as sNaN, qNaN, inf, zero, subnormal or normal.
REQ-014 CLASS SHALL unpack a normal operand to signed exponent e-15 and significand {1,frac}.
REQ-015 CLASS SHALL left-normalize a subnormal operand's significand to bit 10, with exponent -14 minus the shift count.
REQ-016 Special cases SHALL be resolved in CLASS, which then goes straight to DONE.
REQ-017 A NaN operand SHALL give p=16'h7E00; invalid SHALL be set iff either operand is an sNaN.
REQ-018 inf x zero SHALL give p=16'h7E00 with invalid=1.
REQ-019 inf x finite-nonzero SHALL give {sa^sb, 15'h7C00}.
REQ-020 zero x finite SHALL give {sa^sb, 15'h0000}.
REQ-021 All other special-case flags SHALL be 0.
REQ-022 MULT SHALL run exactly 11 cycles of shift-add on the 11-bit significands, one multiplier bit per cycle, into a 22-bit accumulator.
REQ-023 The MULT iteration counter SHALL be 4 bits, load 0 on CLASS exit, and leave MULT when it reaches 10.
REQ-024 Exponent arithmetic SHALL use signed 7-bit width: ea+eb, with range -48..+30, no wrap.
REQ-025 NORM (1 cycle): if product bit 21 is set, shift right by 1 and add 1 to the exponent.
REQ-026 NORM: if the exponent is below -14, shift right by (-14 - exp), capped at 24, and OR the shifted-out bits into sticky; the result is then subnormal.
REQ-027 ROUND (1 cycle) SHALL apply RNE using guard, round and sticky bits.
REQ-028 If rounding carries out of the significand, the exponent SHALL be incremented; subnormal to normal promotion is allowed.
REQ-029 inexact SHALL equal guard|round|sticky.
REQ-030 A final exponent above 15 SHALL give p={s,15'h7C00} with overflow=1 and inexact=1.
REQ-031 underflow=1 iff the result is tiny before rounding and inexact.
REQ-032 An exact zero from underflow SHALL keep the product sign.
REQ-033 DONE SHALL assert done for 1 cycle, then return to IDLE; a start in that DONE cycle is ignored.
REQ-034 p and flags SHALL be registered and hold their values until the next DONE.
REQ-035 Latency, counted from the start-sampling edge as cycle 0, SHALL be: special case done=1 in cycle 2; normal path done=1 in cycle 15 (CLASS 1, MULT 2-12, NORM 13, ROUND 14). It is fixed and independent of operand values.
REQ-036 The minimum start-to-start interval SHALL be 3 cycles for special cases and 16 for the normal path.

Reset
REQ-037 With rst=1 at a rising edge, in any state including mid-MULT, the next state SHALL be IDLE with busy=0, done=0, p=16'h0000, flags=4'b0000, and the counter, accumulator and captured operands cleared.
REQ-038 rst SHALL take priority over start in the same cycle.
REQ-039 A multiply interrupted by rst SHALL never produce a done pulse.

Verification
REQ-040 a=3C00, b=3C00, start at cycle 0 -> busy 1 in cycles 1-15, done=1 only in cycle 15, p=3C00, flags=0000.
REQ-041 a=C000, b=4200 -> p=C600, flags=0000; then a=7BFF, b=7BFF -> p=7C00, flags=0101.
REQ-042 a=7C00, b=0000 -> done in cycle 2, p=7E00, flags=1000; a=7D00 (sNaN), b=3C00 -> p=7E00, flags=1000; a=7E00, b=3C00 -> flags=0000.
REQ-043 a=0001, b=3800 -> p=0000, flags=0011; a=0001, b=4000 -> p=0002, flags=0000; a=0400, b=3800 -> p=0200, flags=0000.
REQ-044 Start a=3C00, b=4000, assert rst in cycle 6 (mid-MULT) -> next cycle busy=0, p=0000, no done; a fresh start then completes normally with p=4000.
REQ-045 start held high continuously with alternating operands -> exactly one done per 16 cycles; operand changes while busy have no effect on p.
